// File: rtl/uart_regs_pkg.sv
// uart_regs_pkg: register bit positions, IIR codes and trigger decode shared by the UART register blocks
package uart_regs_pkg;
  localparam int ENTRY_W = 11;
  localparam int LSR_DR  = 0;
  localparam int LSR_OE  = 1;
  localparam int LSR_PE  = 2;
  localparam int LSR_FE  = 3;
  localparam int LSR_BI  = 4;
  localparam int LSR_ERR = 7;
  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTO  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  function automatic logic [4:0] trigger_decode(input logic [1:0] sel);
    return sel == 2'b00 ? 5'd1 : sel == 2'b01 ? 5'd4 : sel == 2'b10 ? 5'd8 : 5'd14;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive entry storage; full FIFO when fifo_en, otherwise a single slot that overwrites
module uart_rx_fifo import uart_regs_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_en,
  input  logic               clr,
  input  logic               wr,
  input  logic               rd,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [AW:0]        count,
  output logic               ovf,
  output logic               head_load,
  output logic [2:0]         head_err,
  output logic               err_any
);
  localparam logic [AW:0] ONE = 1;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, nxt;
  logic [AW:0] err_cnt;
  logic empty, full, push, pop;
  assign nxt = rd_ptr + 1'b1;
  assign empty = count == '0;
  assign full = fifo_en ? count == (AW+1)'(DEPTH) : !empty;
  assign pop = rd & !empty;
  assign push = wr & !clr & (!full | rd | !fifo_en);
  assign ovf = wr & !clr & full & !rd;
  assign head = mem[rd_ptr];
  assign err_any = err_cnt != '0;
  // An entry becomes head when written into an empty store or when the entry in front of it pops
  assign head_load = !clr & (fifo_en ? (pop & count > ONE) | (push & (empty | (pop & count == ONE))) : push);
  assign head_err = (fifo_en & count > ONE) ? mem[nxt][ENTRY_W-1:8] : din[ENTRY_W-1:8];
  // Entry storage; in single-register mode the pointers stay at slot 0
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  // Pointers, occupancy and count of stored entries carrying an error
  always_ff @(posedge clk)
    if (!reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      err_cnt <= '0;
    end else if (fifo_en) begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      err_cnt <= err_cnt + (AW+1)'(push & |din[ENTRY_W-1:8]) - (AW+1)'(pop & |head[ENTRY_W-1:8]);
    end else
      count <= {{AW{1'b0}}, push | (!empty & !pop)};
endmodule

// File: rtl/uart_rx_buffer_reg.sv
// uart_rx_buffer_reg: UART receive buffer with LSR receive bits, character timeout and IIR generation
module uart_rx_buffer_reg import uart_regs_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int TO_CHARS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rWR,
  input  logic [7:0] Datain,
  input  logic       rx_pe,
  input  logic       rx_fe,
  input  logic       rx_bi,
  input  logic       rRD,
  input  logic       lsr_rd,
  input  logic       char_tick,
  input  logic [7:0] FCR,
  input  logic [7:0] IER,
  output logic [7:0] Dataout,
  output logic [7:0] IIR,
  output logic [7:0] LSR
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TO_CHARS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CHARS);
  logic fifo_en, fifo_en_q, clr, ovf, head_load, err_any, pop, inc, oe, to_flag, rls, rda, cto, unused;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0] count, trig;
  logic [2:0] head_err, lsr_err;
  logic [TW-1:0] to_cnt;
  logic [4:0] trig_raw;
  logic [3:0] iir_id;
  assign unused = ^{FCR[5:2], IER[7:3], IER[1]};
  assign fifo_en = FCR[0];
  assign clr = FCR[1] | (fifo_en ^ fifo_en_q);
  assign pop = rRD & (count != '0);
  assign trig_raw = trigger_decode(FCR[7:6]);
  assign trig = !fifo_en ? CW'(1) : (int'(trig_raw) > DEPTH) ? CW'(DEPTH) : CW'(trig_raw);
  assign inc = char_tick & (count != '0) & !rWR & !rRD & (to_cnt != TO_MAX);
  assign rls = IER[2] & (oe | (|lsr_err));
  assign rda = IER[0] & (count >= trig);
  assign cto = IER[0] & to_flag;
  assign iir_id = rls ? IIR_RLS : rda ? IIR_RDA : cto ? IIR_CTO : IIR_NONE;
  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .fifo_en(fifo_en),
    .clr(clr),
    .wr(rWR),
    .rd(rRD),
    .din({rx_bi, rx_fe, rx_pe, Datain}),
    .head(head),
    .count(count),
    .ovf(ovf),
    .head_load(head_load),
    .head_err(head_err),
    .err_any(err_any)
  );
  // Previous FIFO-enable value, so a mode change can flush storage
  always_ff @(posedge clk) fifo_en_q <= reset ? fifo_en : 1'b0;
  // Read data and sticky line-status bits; a new error beats a coincident LSR read
  always_ff @(posedge clk)
    if (!reset) begin
      Dataout <= '0;
      oe <= 1'b0;
      lsr_err <= '0;
    end else begin
      if (pop) Dataout <= head[7:0];
      oe <= (oe & !lsr_rd) | ovf;
      lsr_err <= (lsr_err & {3{!lsr_rd}}) | (head_load ? head_err : 3'b000);
    end
  // Character-timeout counter and flag, active only in FIFO mode
  always_ff @(posedge clk)
    if (!reset || clr || !fifo_en) begin
      to_cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      to_cnt <= (rWR | rRD) ? '0 : to_cnt + TW'(inc);
      to_flag <= !rRD & (to_flag | (inc & (to_cnt == TO_MAX - 1'b1)));
    end
  // Interrupt identification, registered one cycle behind its cause
  always_ff @(posedge clk) IIR <= !reset ? 8'h01 : {{2{fifo_en}}, 2'b00, iir_id};
  // Line status assembled from storage state and sticky bits
  always_comb begin
    LSR = '0;
    LSR[LSR_DR] = count != '0;
    LSR[LSR_OE] = oe;
    LSR[LSR_BI:LSR_PE] = lsr_err;
    LSR[LSR_ERR] = fifo_en & err_any;
  end
endmodule

// File: tb/tb_uart_rx_buffer_reg.sv
// tb_uart_rx_buffer_reg: scoreboard bench with a queue-based reference model of the receive buffer
module tb_uart_rx_buffer_reg;
  localparam int DEPTH = 16;
  localparam int TO = 4;
  logic clk = 0, reset = 0, rWR = 0, rx_pe = 0, rx_fe = 0, rx_bi = 0, rRD = 0, lsr_rd = 0, char_tick = 0;
  logic [7:0] Datain = 0, FCR = 0, IER = 0;
  logic [7:0] Dataout, IIR, LSR;
  int total = 0, bad = 0;
  typedef struct {int id; logic [10:0] e;} ent_t;
  ent_t q[$];
  logic [7:0] exp_dout[$];
  int nid = 0, m_tcnt = 0;
  logic m_oe = 0, m_tflag = 0, m_fprev = 0;
  logic [2:0] m_perr = 0;
  logic [7:0] m_iir = 8'h01;
  bit rd_seen = 0;

  always #5 clk = ~clk;

  uart_rx_buffer_reg #(.DEPTH(DEPTH), .TO_CHARS(TO)) dut (
    .clk(clk), .reset(reset), .rWR(rWR), .Datain(Datain), .rx_pe(rx_pe), .rx_fe(rx_fe),
    .rx_bi(rx_bi), .rRD(rRD), .lsr_rd(lsr_rd), .char_tick(char_tick), .FCR(FCR), .IER(IER),
    .Dataout(Dataout), .IIR(IIR), .LSR(LSR)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int trig_lvl();
    int t = FCR[7:6] == 2'd0 ? 1 : FCR[7:6] == 2'd1 ? 4 : FCR[7:6] == 2'd2 ? 8 : 14;
    if (t > DEPTH) t = DEPTH;
    return FCR[0] ? t : 1;
  endfunction

  function automatic logic [7:0] m_lsr();
    logic any = 0;
    foreach (q[i]) if (|q[i].e[10:8]) any = 1;
    return {FCR[0] & any, 2'b00, m_perr, m_oe, q.size() > 0};
  endfunction

  task automatic model_reset();
    q.delete();
    m_oe = 0; m_perr = 0; m_tcnt = 0; m_tflag = 0; m_iir = 8'h01; m_fprev = 0;
  endtask

  task automatic model_step();
    logic fifo = FCR[0];
    logic clr = FCR[1] | (FCR[0] != m_fprev);
    int cnt = q.size();
    int h0 = cnt > 0 ? q[0].id : -1;
    logic ovf = 0, inc;
    logic [3:0] id;
    ent_t n;
    if (IER[2] && (m_oe || |m_perr)) id = 4'b0110;
    else if (IER[0] && cnt >= trig_lvl()) id = 4'b0100;
    else if (IER[0] && m_tflag) id = 4'b1100;
    else id = 4'b0001;
    m_iir = {fifo, fifo, 2'b00, id};
    inc = fifo && !clr && char_tick && cnt > 0 && !rWR && !rRD && m_tcnt < TO;
    m_tflag = (clr || !fifo || rRD) ? 1'b0 : (m_tflag || (inc && m_tcnt + 1 == TO));
    m_tcnt = (clr || !fifo || rWR || rRD) ? 0 : m_tcnt + (inc ? 1 : 0);
    if (rRD && cnt > 0) begin
      exp_dout.push_back(q[0].e[7:0]);
      rd_seen = 1;
      void'(q.pop_front());
    end
    if (clr) q.delete();
    else if (rWR) begin
      n.id = nid++;
      n.e = {rx_bi, rx_fe, rx_pe, Datain};
      if (!fifo) begin
        ovf = q.size() > 0;
        q.delete();
        q.push_back(n);
      end else if (q.size() < DEPTH) q.push_back(n);
      else ovf = 1;
    end
    m_oe = (m_oe && !lsr_rd) || ovf;
    if (lsr_rd) m_perr = 3'b000;
    if (!clr && q.size() > 0 && q[0].id != h0) m_perr = m_perr | q[0].e[10:8];
    m_fprev = fifo;
  endtask

  task automatic cyc(input logic wr = 1'b0, input logic [7:0] d = 8'h00, input logic [2:0] err = 3'b000,
                     input logic rd = 1'b0, input logic lrd = 1'b0, input logic tick = 1'b0);
    rWR = wr; Datain = d; {rx_bi, rx_fe, rx_pe} = err; rRD = rd; lsr_rd = lrd; char_tick = tick;
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    @(negedge clk);
    rWR = 0; rRD = 0; lsr_rd = 0; char_tick = 0;
    chk("lsr", LSR, m_lsr());
    chk("iir", IIR, m_iir);
  endtask

  always @(negedge clk)
    if (rd_seen) begin
      rd_seen = 0;
      chk("dout", Dataout, exp_dout.pop_front());
    end

  initial begin
    logic w, r;
    logic [2:0] e;
    int p;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_dout", Dataout, 8'h00);
    chk("rst_lsr", LSR, 8'h00);
    chk("rst_iir", IIR, 8'h01);
    reset = 1;
    cyc(1'b1, 8'hA5);
    chk("nf_dr", LSR & 8'h01, 8'h01);
    cyc(.rd(1'b1));
    chk("nf_data", Dataout, 8'hA5);
    chk("nf_dr0", LSR & 8'h01, 8'h00);
    cyc(1'b1, 8'h11); cyc(1'b1, 8'h3C); cyc(.rd(1'b1));
    chk("nf_over_data", Dataout, 8'h3C);
    chk("nf_oe", LSR & 8'h02, 8'h02);
    cyc(.lrd(1'b1));
    chk("nf_oe_clr", LSR & 8'h02, 8'h00);
    FCR = 8'h41; IER = 8'h01;
    cyc();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i));
    cyc();
    chk("rda_below", IIR, 8'hC1);
    cyc(1'b1, 8'h13); cyc();
    chk("rda_at", IIR, 8'hC4);
    repeat (4) cyc(.rd(1'b1));
    cyc();
    chk("rda_drained", IIR, 8'hC1);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'($urandom));
    chk("full_oe", LSR & 8'h02, 8'h02);
    cyc(.lrd(1'b1));
    cyc(1'b1, 8'h77, 3'b000, 1'b1);
    chk("full_wr_rd_no_oe", LSR & 8'h02, 8'h00);
    repeat (DEPTH) cyc(.rd(1'b1));
    cyc();
    chk("full_drained", LSR & 8'h01, 8'h00);
    cyc(1'b1, 8'h21); cyc(1'b1, 8'h22, 3'b010);
    chk("err_pending", LSR & 8'h88, 8'h80);
    cyc(.rd(1'b1));
    chk("err_head_fe", LSR & 8'h08, 8'h08);
    IER = 8'h04;
    cyc();
    chk("rls_iir", IIR, 8'hC6);
    cyc(.lrd(1'b1));
    chk("fe_clr", LSR & 8'h08, 8'h00);
    cyc(.rd(1'b1)); cyc();
    chk("err_gone", LSR & 8'h80, 8'h00);
    IER = 8'h01;
    cyc(1'b1, 8'h5A);
    repeat (TO) begin
      cyc(.tick(1'b1));
      cyc();
    end
    chk("timeout_iir", IIR, 8'hCC);
    cyc(.rd(1'b1)); cyc();
    chk("timeout_clr", IIR, 8'hC1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i));
    FCR = 8'h43; cyc(); FCR = 8'h41; cyc();
    chk("clr_dr", LSR & 8'h01, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i));
    cyc(.rd(1'b1));
    reset = 0; cyc(); reset = 1;
    chk("rst2_dr", LSR & 8'h01, 8'h00);
    chk("rst2_iir", IIR, 8'h01);
    chk("rst2_dout", Dataout, 8'h00);
    for (int i = 0; i < 1200; i++) begin
      p = (i / 100) % 2;
      if ($urandom_range(39, 0) == 0) begin
        FCR = 8'($urandom) & 8'hC2;
        if ($urandom_range(3, 0) != 0) FCR[0] = 1'b1;
        cyc();
        FCR[1] = 1'b0;
        cyc();
      end else begin
        if ($urandom_range(15, 0) == 0) IER = {5'b0, 1'($urandom), 1'b0, 1'($urandom)};
        w = $urandom_range(3, 0) < (p != 0 ? 1 : 3);
        r = $urandom_range(3, 0) < (p != 0 ? 3 : 1);
        e = $urandom_range(5, 0) == 0 ? 3'($urandom) : 3'b000;
        cyc(w, 8'($urandom), e, r, $urandom_range(7, 0) == 0, $urandom_range(2, 0) == 0);
      end
    end
    repeat (3) cyc();
    chk("sb_left", 8'(exp_dout.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
